// File: rtl/hvsync_pkg.sv
// hvsync_pkg: default raster geometry, derived constants and position type
package hvsync_pkg;
  typedef logic [8:0] pos_t;
  localparam int H_DISPLAY_DEF = 256;
  localparam int H_BACK_DEF = 23;
  localparam int H_FRONT_DEF = 7;
  localparam int H_SYNC_DEF = 23;
  localparam int V_DISPLAY_DEF = 240;
  localparam int V_TOP_DEF = 5;
  localparam int V_BOTTOM_DEF = 14;
  localparam int V_SYNC_DEF = 3;
  localparam int H_MAX = H_DISPLAY_DEF + H_BACK_DEF + H_FRONT_DEF + H_SYNC_DEF - 1;
  localparam int H_SYNC_START = H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int V_MAX = V_DISPLAY_DEF + V_TOP_DEF + V_BOTTOM_DEF + V_SYNC_DEF - 1;
  localparam int V_SYNC_START = V_DISPLAY_DEF + V_BOTTOM_DEF;
  localparam int V_SYNC_END = V_SYNC_START + V_SYNC_DEF - 1;
  function automatic logic in_window(pos_t p, int lo, int hi);
    return int'(p) >= lo && int'(p) <= hi;
  endfunction
endpackage

// File: rtl/hvsync_timing_generator_wrap_counter.sv
// wrap_counter: 9-bit enabled counter that returns to 0 after MAX
module wrap_counter
  import hvsync_pkg::*;
#(
  parameter int MAX = 308
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output pos_t count,
  output logic wrap
);
  assign wrap = count == pos_t'(MAX);
  // count up when enabled; compare-to-max is the only wrap path
  always_ff @(posedge clk)
    count <= (reset || (en && wrap)) ? '0 : count + pos_t'(en);
endmodule

// File: rtl/hvsync_timing_generator.sv
// hvsync_timing_generator: raster position, registered syncs (active-low with HVSYNC_SYNC_INVERT_EN)
module hvsync_timing_generator
  import hvsync_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_BACK = H_BACK_DEF,
  parameter int H_FRONT = H_FRONT_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_TOP = V_TOP_DEF,
  parameter int V_BOTTOM = V_BOTTOM_DEF,
  parameter int V_SYNC = V_SYNC_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic hsync,
  output logic vsync,
  output logic display_on,
  output pos_t hpos,
  output pos_t vpos
);
  localparam int HMAX = H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END = HS_START + H_SYNC - 1;
  localparam int VMAX = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_BOTTOM;
  localparam int VS_END = VS_START + V_SYNC - 1;
`ifdef HVSYNC_SYNC_INVERT_EN
  localparam logic SYNC_IDLE = 1'b1;
`else
  localparam logic SYNC_IDLE = 1'b0;
`endif
  logic h_wrap;
  wrap_counter #(.MAX(HMAX)) u_h (
    .clk(clk), .reset(reset), .en(1'b1), .count(hpos), .wrap(h_wrap)
  );
  wrap_counter #(.MAX(VMAX)) u_v (
    .clk(clk), .reset(reset), .en(h_wrap), .count(vpos), .wrap()
  );
  // syncs lag the position by one clock; reset forces the idle level
  always_ff @(posedge clk) begin
    hsync <= SYNC_IDLE ^ (!reset && in_window(hpos, HS_START, HS_END));
    vsync <= SYNC_IDLE ^ (!reset && in_window(vpos, VS_START, VS_END));
  end
  assign display_on = int'(hpos) < H_DISPLAY && int'(vpos) < V_DISPLAY;
endmodule

// File: tb/tb_hvsync_timing_generator.sv
// tb_hvsync_timing_generator: cycle-index model of the raster plus literal pin checks
module tb_hvsync_timing_generator;
  localparam int LINE = 309;
  localparam int FRAME = 262 * LINE;
  localparam int MID = FRAME + LINE + 270;
`ifdef HVSYNC_SYNC_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif
  logic clk = 0, reset = 1;
  logic hsync, vsync, display_on;
  logic [8:0] hpos, vpos;
  int n = 0, checks = 0, errors = 0, pass = 0;
  int vs_cnt = 0, hs_cnt = 0, hs_rises = 0;
  bit run = 0;
  logic hs_prev = 0;
  hvsync_timing_generator dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .display_on(display_on), .hpos(hpos), .vpos(vpos)
  );
  always #5 clk = ~clk;
  // position after n clocks since reset: plain modular arithmetic
  function automatic int mh(int k); return k % LINE; endfunction
  function automatic int mv(int k); return (k / LINE) % 262; endfunction
  function automatic logic mhs(int k);
    return k > 0 && mh(k - 1) >= 263 && mh(k - 1) <= 285;
  endfunction
  function automatic logic mvs(int k);
    return k > 0 && mv(k - 1) >= 254 && mv(k - 1) <= 256;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s pass=%0d n=%0d got %0d expected %0d", name, pass, n, act, exp);
    end
  endtask
  logic hs_act, vs_act;
  assign hs_act = hsync ^ INV;
  assign vs_act = vsync ^ INV;
  always @(negedge clk) if (run) begin
    chk("hpos", 32'(hpos), 32'(mh(n)));
    chk("vpos", 32'(vpos), 32'(mv(n)));
    chk("hsync", 32'(hs_act), 32'(mhs(n)));
    chk("vsync", 32'(vs_act), 32'(mvs(n)));
    chk("display_on", 32'(display_on), 32'(mh(n) < 256 && mv(n) < 240));
    if (n == 0) begin
      chk("rst_hpos", 32'(hpos), 0);
      chk("rst_vpos", 32'(vpos), 0);
      chk("rst_hsync", 32'(hsync), 32'(INV));
      chk("rst_vsync", 32'(vsync), 32'(INV));
      chk("rst_disp", 32'(display_on), 1);
    end
    if (n == 1) chk("lit_hpos1", 32'(hpos), 1);
    if (n == 255) chk("lit_disp255", 32'(display_on), 1);
    if (n == 256) chk("lit_disp256", 32'(display_on), 0);
    if (n == 263) chk("lit_hs263", 32'(hs_act), 0);
    if (n == 264) chk("lit_hs264", 32'(hs_act), 1);
    if (n == 286) chk("lit_hs286", 32'(hs_act), 1);
    if (n == 287) chk("lit_hs287", 32'(hs_act), 0);
    if (n == 308) chk("lit_hmax", 32'(hpos), 308);
    if (n == 309) chk("lit_line_wrap", {hpos, vpos}, {9'd0, 9'd1});
    if (n == 240 * LINE) chk("lit_vblank", {23'(vpos), display_on}, {23'd240, 1'b0});
    if (n == 254 * LINE) chk("lit_vs_pre", 32'(vs_act), 0);
    if (n == 254 * LINE + 1) chk("lit_vs_rise", 32'(vs_act), 1);
    if (n == 257 * LINE) chk("lit_vs_last", 32'(vs_act), 1);
    if (n == 257 * LINE + 1) chk("lit_vs_fall", 32'(vs_act), 0);
    if (n == FRAME - 1) chk("lit_frame_end", {hpos, vpos}, {9'd308, 9'd261});
    if (n == FRAME) chk("lit_frame_wrap", {hpos, vpos}, {9'd0, 9'd0});
    if (pass == 0 && n < FRAME) begin
      vs_cnt += int'(vs_act);
      if (n < LINE) hs_cnt += int'(hs_act);
      if (hs_act && !hs_prev) hs_rises++;
    end
    if (pass == 0 && n == FRAME) begin
      chk("vsync_width", vs_cnt, 927);
      chk("hsync_width", hs_cnt, 23);
      chk("hsync_pulses", hs_rises, 262);
    end
    hs_prev = hs_act;
    n++;
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    run = 1;
    repeat (MID) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    n = 0;
    pass = 1;
    hs_prev = 0;
    repeat (400) @(posedge clk);
    #1 run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hvsync_timing_generator.md
# hvsync_timing_generator

Free-running raster timing generator for the 256×240 video pipeline. It produces the horizontal/vertical beam position, registered sync pulses and a display-enable flag from a single pixel clock. Every sprite, playfield and colour block in the design keys its pixel logic off `hpos`/`vpos`/`display_on`, and line-rate logic clocks on `hsync`.

## Interface
Parameters:
- `H_DISPLAY`, 256: visible pixels per line
- `H_BACK`, 23: left border (back porch), in pixels
- `H_FRONT`, 7: right border (front porch), in pixels
- `H_SYNC`, 23: hsync pulse width, in pixels
- `V_DISPLAY`, 240: visible lines per frame
- `V_TOP`, 5: top border, in lines
- `V_BOTTOM`, 14: bottom border, in lines
- `V_SYNC`, 3: vsync pulse width, in lines

Ports:
- `clk`  in  1  pixel clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `hsync`  out  1  horizontal sync, registered, active-high by default
- `vsync`  out  1  vertical sync, registered, active-high by default
- `display_on`  out  1  high when the beam is inside the visible area
- `hpos`  out  9  current pixel column, 0 .. H_MAX
- `vpos`  out  9  current line, 0 .. V_MAX

## Operation
- Derived constants: H_MAX = H_DISPLAY+H_BACK+H_FRONT+H_SYNC−1 = 308; H_SYNC_START = H_DISPLAY+H_FRONT = 263; H_SYNC_END = H_SYNC_START+H_SYNC−1 = 285. V_MAX = V_DISPLAY+V_TOP+V_BOTTOM+V_SYNC−1 = 261; V_SYNC_START = V_DISPLAY+V_BOTTOM = 254; V_SYNC_END = 256.
- `hpos` increments every cycle. When `hpos` == H_MAX, or `reset` is high, it loads 0 on the next edge.
- `vpos` changes only on cycles where `hpos` == H_MAX or `reset` is high. In those cycles it loads 0 if `vpos` == V_MAX or `reset` is high; otherwise it increments.
- `hsync` register loads (H_SYNC_START ≤ `hpos` ≤ H_SYNC_END).
- `vsync` register loads (V_SYNC_START ≤ `vpos` ≤ V_SYNC_END).
- `display_on` is combinational: (`hpos` < H_DISPLAY) && (`vpos` < V_DISPLAY).
- Line period is 309 clocks. Frame period is 262 × 309 = 80 958 clocks.
- All counters are unsigned, 9 bits wide. Counters never wrap naturally; the compare-to-max terms are the only wrap mechanism.

## Timing
- Reset values: `hpos` = 0, `vpos` = 0, `hsync` = 0, `vsync` = 0. Consequently `display_on` = 1 immediately after reset.
- A reset asserted mid-frame takes effect on the next edge regardless of position. No partial pulse may persist after that edge.
- Sync latency is one clock. `hsync` rises on the edge after `hpos` = 263, so it is first seen high while `hpos` = 264. It stays high for 23 clocks and first falls while `hpos` = 287.
- `vsync` has the same one-clock lag relative to `vpos`. It is high for 3 × 309 clocks.
- At end of frame (`hpos` = 308, `vpos` = 261), both counters return to 0 on the same edge.

## Configuration
- Macro `HVSYNC_SYNC_INVERT_EN`:
  - Defined: `hsync` and `vsync` are active-low. Their reset value is 1, and each register loads the negated window compare.
  - Undefined: active-high, as described above.
- `display_on`, `hpos` and `vpos` are unaffected by the macro.

## Structure
- Package `hvsync_pkg` holds the default geometry constants and the derived constants (H_MAX, V_MAX, sync start/end), plus the 9-bit position typedef `pos_t`.
- One sub-module, `wrap_counter`, is natural. It is a 9-bit counter with a MAX parameter, an `en` input, a sync `reset` input and a `wrap` output. Instantiate it twice: the horizontal counter always enabled, and the vertical counter enabled by the horizontal counter's `wrap`.

## Test plan
- Reset held for 3 cycles, then released → `hpos` = 0, `vpos` = 0, `hsync` = 0, `vsync` = 0, `display_on` = 1; `hpos` = 1 on the next cycle.
- Run one line → `hpos` counts 0..308 and then reads 0, `vpos` steps 0→1, and `display_on` falls at `hpos` = 256.
- Measure `hsync` → rising edge while `hpos` = 264, high for exactly 23 clocks, exactly one pulse per 309 clocks.
- Run a full frame → `vpos` counts 0..261 and then reads 0 after 80 958 clocks; `display_on` is 0 for `vpos` in 240..261.
- Measure `vsync` → high from the clock after `vpos` becomes 254 through the clock after `vpos` becomes 257, i.e. 927 clocks.
- Assert reset at `hpos` = 150, `vpos` = 100 → next cycle `hpos` = 0, `vpos` = 0, and sync outputs are inactive.
